// File: rtl/alu_pkg.sv
// Shared opcode/state types and default width for the sequential ALU.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } alu_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles total.
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               busy;

    // The start edge already performs iteration 0 on the live operands, so
    // the final iteration lands WIDTH-1 edges later and done is seen at edge WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier <= b >> 1;
                cnt    <= SHW'(1);
                busy   <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU with registered result and V/C/N/Z flags.
// Define ALU_MUL_EN to enable the multi-cycle MUL opcode; otherwise MUL returns zero.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             negative,
    output logic             zero
);

    alu_state_t       state;
    alu_state_t       state_d;
    logic             accept;
    logic             is_mul;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   sll_ext;
    logic [WIDTH:0]   sra_ext;
    logic [WIDTH-1:0] res_d;
    logic             v_d;
    logic             c_d;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];

    // Extra bit on each shifter catches the last bit shifted out (zero for shamt 0).
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign sll_ext = {1'b0, a} << shamt;
    assign sra_ext = $unsigned($signed({a, 1'b0}) >>> shamt);

`ifdef ALU_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    assign is_mul = (op == OP_MUL);

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        res_d = '0;
        v_d   = 1'b0;
        c_d   = 1'b0;
        case (op)
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff[WIDTH-1:0];
                c_d   = diff[WIDTH];
                v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_SLL: begin
                res_d = sll_ext[WIDTH-1:0];
                c_d   = sll_ext[WIDTH];
            end
            OP_SRA: begin
                res_d = sra_ext[WIDTH:1];
                c_d   = sra_ext[0];
            end
            default: res_d = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = is_mul ? EXEC : DONE;
                end
            end
`ifdef ALU_MUL_EN
            EXEC: begin
                if (mul_done) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
        end else if (accept && !is_mul) begin
            result   <= res_d;
            overflow <= v_d;
            carry    <= c_d;
            negative <= res_d[WIDTH-1];
            zero     <= (res_d == '0);
`ifdef ALU_MUL_EN
        end else if (state == EXEC && mul_done) begin
            // Any nonzero high half means the low-half result has wrapped.
            result   <= product[WIDTH-1:0];
            overflow <= |product[2*WIDTH-1:WIDTH];
            carry    <= |product[2*WIDTH-1:WIDTH];
            negative <= product[WIDTH-1];
            zero     <= (product[WIDTH-1:0] == '0);
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8 (MUL expectations follow ALU_MUL_EN).
module tb_seq_alu;
    import alu_pkg::*;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid_32 = 1'b0, in_ready_32, out_valid_32, out_ready_32 = 1'b0;
    logic [31:0] a_32 = '0, b_32 = '0, result_32;
    alu_op_t     op_32 = OP_ADD;
    logic        ovf_32, cy_32, neg_32, zero_32;

    logic        in_valid_8 = 1'b0, in_ready_8, out_valid_8, out_ready_8 = 1'b0;
    logic [7:0]  a_8 = '0, b_8 = '0, result_8;
    alu_op_t     op_8 = OP_ADD;
    logic        ovf_8, cy_8, neg_8, zero_8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut_32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_32), .in_ready(in_ready_32),
        .a(a_32), .b(b_32), .op(op_32), .out_valid(out_valid_32), .out_ready(out_ready_32),
        .result(result_32), .overflow(ovf_32), .carry(cy_32), .negative(neg_32), .zero(zero_32)
    );

    seq_alu #(.WIDTH(8)) dut_8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .op(op_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .result(result_8), .overflow(ovf_8), .carry(cy_8), .negative(neg_8), .zero(zero_8)
    );

    typedef struct {
        int                w;
        logic [2:0]        op;
        longint unsigned   a;
        longint unsigned   b;
        longint unsigned   res;
        logic [3:0]        flg;
        int                lat;
    } vec_t;

    vec_t vecs[$];

    function automatic logic out_valid_of(input int w);
        return (w == 8) ? out_valid_8 : out_valid_32;
    endfunction

    function automatic logic in_ready_of(input int w);
        return (w == 8) ? in_ready_8 : in_ready_32;
    endfunction

    function automatic longint unsigned result_of(input int w);
        return (w == 8) ? longint'(result_8) : longint'(result_32);
    endfunction

    function automatic logic [3:0] flags_of(input int w);
        return (w == 8) ? {ovf_8, cy_8, neg_8, zero_8} : {ovf_32, cy_32, neg_32, zero_32};
    endfunction

    // Reference model: plain integer arithmetic on the operands' mathematical values.
    function automatic void model(input int w, input logic [2:0] opc,
                                  input longint unsigned a_in, input longint unsigned b_in,
                                  output longint unsigned res, output logic [3:0] flg);
        longint unsigned modv, mask, av, bv, full;
        longint sa, sb, sres, half;
        int s;
        logic v, c;
        modv = 64'd1 << w;
        mask = modv - 1;
        av   = a_in & mask;
        bv   = b_in & mask;
        half = longint'(modv >> 1);
        sa   = longint'(av);
        sb   = longint'(bv);
        if (sa >= half) sa = sa - longint'(modv);
        if (sb >= half) sb = sb - longint'(modv);
        s    = int'(bv & longint'(w - 1));
        v    = 1'b0;
        c    = 1'b0;
        res  = 0;
        case (opc)
            3'd0: begin
                full = av + bv;
                res  = full & mask;
                c    = (full >= modv);
                sres = sa + sb;
                v    = (sres >= half) || (sres < -half);
            end
            3'd1: begin
                res  = (av - bv) & mask;
                c    = (av >= bv);
                sres = sa - sb;
                v    = (sres >= half) || (sres < -half);
            end
            3'd2: res = av & bv;
            3'd3: res = av | bv;
            3'd4: res = av ^ bv;
            3'd5: begin
                res = (av << s) & mask;
                c   = (s != 0) && (((av >> (w - s)) & 1) == 1);
            end
            3'd6: begin
                res = $unsigned(sa >>> s) & mask;
                c   = (s != 0) && (((av >> (s - 1)) & 1) == 1);
            end
            default: begin
                if (MUL_EN) begin
                    full = av * bv;
                    res  = full & mask;
                    c    = ((full >> w) != 0);
                    v    = c;
                end
            end
        endcase
        flg = {v, c, ((res >> (w - 1)) & 1) == 1, res == 0};
    endfunction

    task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int w, input logic [2:0] opc,
                                 input longint unsigned av, input longint unsigned bv);
        if (w == 8) begin
            in_valid_8 = 1'b1;
            op_8       = alu_op_t'(opc);
            a_8        = av[7:0];
            b_8        = bv[7:0];
        end else begin
            in_valid_32 = 1'b1;
            op_32       = alu_op_t'(opc);
            a_32        = av[31:0];
            b_32        = bv[31:0];
        end
    endtask

    // Accept one operation, wait (bounded) for out_valid, sample, then release it.
    // lat counts edges after the accept edge until out_valid is seen.
    task automatic runOp(input int w, input logic [2:0] opc,
                         input longint unsigned av, input longint unsigned bv,
                         output longint unsigned res, output logic [3:0] flg,
                         output int lat, output logic busy_ok, output logic ready_after);
        applyStimulus(w, opc, av, bv);
        @(posedge clk); #1;
        in_valid_8  = 1'b0;
        in_valid_32 = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid_of(w) && lat < 200) begin
            if (in_ready_of(w)) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = result_of(w);
        flg = flags_of(w);
        if (w == 8) out_ready_8 = 1'b1; else out_ready_32 = 1'b1;
        @(posedge clk); #1;
        out_ready_8  = 1'b0;
        out_ready_32 = 1'b0;
        ready_after  = in_ready_of(w);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        longint unsigned res, exp_res;
        logic [3:0]      flg, exp_flg;
        int              lat, w;
        logic            busy_ok, ready_after;
        logic [2:0]      opc;
        longint unsigned av, bv;

        vecs.push_back('{32, 3'd0, 64'h80000000, 64'h80000001, 64'h00000001, 4'b1100, 0});
        vecs.push_back('{32, 3'd0, 64'h7FFFFFFF, 64'h00000001, 64'h80000000, 4'b1010, 0});
        vecs.push_back('{32, 3'd1, 64'd40,       64'd40,       64'h00000000, 4'b0101, 0});
        vecs.push_back('{32, 3'd1, 64'd0,        64'd1,        64'hFFFFFFFF, 4'b0010, 0});
        vecs.push_back('{32, 3'd4, 64'h55555555, 64'hAAAAAAAA, 64'hFFFFFFFF, 4'b0010, 0});
        vecs.push_back('{32, 3'd2, 64'h55555555, 64'hAAAAAAAA, 64'h00000000, 4'b0001, 0});
        vecs.push_back('{32, 3'd3, 64'h000000F0, 64'h0000000F, 64'h000000FF, 4'b0000, 0});
        vecs.push_back('{32, 3'd5, 64'h80000001, 64'd1,        64'h00000002, 4'b0100, 0});
        vecs.push_back('{32, 3'd5, 64'hF0000000, 64'h20,       64'hF0000000, 4'b0010, 0});
        vecs.push_back('{32, 3'd5, 64'd3,        64'd31,       64'h80000000, 4'b0110, 0});
        vecs.push_back('{32, 3'd6, 64'h80000000, 64'd4,        64'hF8000000, 4'b0010, 0});
        vecs.push_back('{32, 3'd6, 64'h80000008, 64'h24,       64'hF8000000, 4'b0110, 0});
        vecs.push_back('{8,  3'd0, 64'h80,       64'h81,       64'h01,       4'b1100, 0});
        vecs.push_back('{8,  3'd1, 64'h28,       64'h28,       64'h00,       4'b0101, 0});
        vecs.push_back('{8,  3'd1, 64'h00,       64'h01,       64'hFF,       4'b0010, 0});
        vecs.push_back('{8,  3'd4, 64'h55,       64'hAA,       64'hFF,       4'b0010, 0});
        vecs.push_back('{8,  3'd2, 64'h55,       64'hAA,       64'h00,       4'b0001, 0});
        vecs.push_back('{8,  3'd5, 64'h81,       64'h01,       64'h02,       4'b0100, 0});
        vecs.push_back('{8,  3'd6, 64'h81,       64'h01,       64'hC0,       4'b0110, 0});
`ifdef ALU_MUL_EN
        vecs.push_back('{32, 3'd7, 64'h0E000001, 64'h0003000F, 64'hD203000F, 4'b1110, 32});
        vecs.push_back('{8,  3'd7, 64'h0F,       64'h11,       64'hFF,       4'b0010, 8});
        vecs.push_back('{8,  3'd7, 64'h10,       64'h10,       64'h00,       4'b1101, 8});
`else
        vecs.push_back('{32, 3'd7, 64'h0E000001, 64'h0003000F, 64'h00000000, 4'b0001, 0});
        vecs.push_back('{8,  3'd7, 64'h0F,       64'h11,       64'h00,       4'b0001, 0});
`endif

        // Reset values while rst is still asserted.
        #1;
        checkOutput("reset_result", result_of(32), 0);
        checkOutput("reset_flags", flags_of(32), 0);
        checkOutput("reset_out_valid", out_valid_32, 0);
        checkOutput("reset_in_ready", in_ready_32, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            runOp(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, res, flg, lat, busy_ok, ready_after);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].res);
            checkOutput($sformatf("vec%0d_flags", i), flg, vecs[i].flg);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            checkOutput($sformatf("vec%0d_ready_after", i), ready_after, 1);
            if (vecs[i].lat > 0) checkOutput($sformatf("vec%0d_in_ready_low", i), busy_ok, 1);
        end

        $display("[TB] backpressure");
        applyStimulus(32, 3'd0, 3, 4);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            in_valid_32  = 1'b1;
            op_32        = OP_SUB;
            a_32         = $urandom;
            b_32         = $urandom;
            out_ready_32 = 1'b0;
            @(posedge clk); #1;
            checkOutput("bp_result", result_of(32), 7);
            checkOutput("bp_flags", flags_of(32), 0);
            checkOutput("bp_in_ready", in_ready_32, 0);
            checkOutput("bp_out_valid", out_valid_32, 1);
        end
        in_valid_32  = 1'b0;
        out_ready_32 = 1'b1;
        @(posedge clk); #1;
        out_ready_32 = 1'b0;
        checkOutput("bp_release_in_ready", in_ready_32, 1);
        checkOutput("bp_release_out_valid", out_valid_32, 0);
        checkOutput("bp_release_result", result_of(32), 7);

        $display("[TB] reset during DONE");
        applyStimulus(32, 3'd0, 5, 6);
        @(posedge clk); #1;
        in_valid_32 = 1'b0;
        checkOutput("done_pre_reset_result", result_of(32), 11);
        rst = 1'b1;
        #1;
        checkOutput("done_rst_out_valid", out_valid_32, 0);
        checkOutput("done_rst_in_ready", in_ready_32, 1);
        checkOutput("done_rst_result", result_of(32), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

`ifdef ALU_MUL_EN
        $display("[TB] reset during EXEC");
        runOp(32, 3'd0, 5, 6, res, flg, lat, busy_ok, ready_after);
        applyStimulus(32, 3'd7, 64'h0E000001, 64'h0003000F);
        @(posedge clk); #1;
        in_valid_32 = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("exec_in_ready_low", in_ready_32, 0);
        rst = 1'b1;
        #1;
        checkOutput("exec_rst_out_valid", out_valid_32, 0);
        checkOutput("exec_rst_in_ready", in_ready_32, 1);
        checkOutput("exec_rst_result", result_of(32), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
`endif
        runOp(32, 3'd0, 3, 4, res, flg, lat, busy_ok, ready_after);
        checkOutput("post_reset_add", res, 7);
        checkOutput("post_reset_latency", lat, 0);

        $display("[TB] random stimulus");
        for (int i = 0; i < 150; i++) begin
            w   = ($urandom_range(0, 1) == 1) ? 8 : 32;
            opc = 3'($urandom_range(0, 7));
            av  = {$urandom, $urandom};
            bv  = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) bv = 0;
            model(w, opc, av, bv, exp_res, exp_flg);
            runOp(w, opc, av, bv, res, flg, lat, busy_ok, ready_after);
            checkOutput($sformatf("rnd%0d_w%0d_op%0d_result", i, w, opc), res, exp_res);
            checkOutput($sformatf("rnd%0d_w%0d_op%0d_flags", i, w, opc), flg, exp_flg);
            checkOutput($sformatf("rnd%0d_latency", i), lat, (MUL_EN && opc == 3'd7) ? w : 0);
            checkOutput($sformatf("rnd%0d_ready_after", i), ready_after, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
